// File: rtl/lix_pkg.sv
// Shared helpers for the lix_* blocks: width functions and the never-happens check macro.
`ifndef LIX_PKG_SVH
`define LIX_PKG_SVH

// Flags a condition that must never hold outside reset, sampled on the rising edge.
`define LIX_ASSERT_NEVER(clk, rst, cond, msg) \
  always @(posedge clk) begin \
    assert ((rst) || !(cond)) else $error(msg); \
  end

`endif

package lix_pkg;

  // Width of an occupancy counter that must hold 0..d inclusive.
  function automatic int unsigned lix_cnt_w(input int unsigned d);
    return $clog2(d + 1);
  endfunction

  // Width of a pointer addressing d entries (at least one bit).
  function automatic int unsigned lix_ptr_w(input int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/lix_fifo_s.sv
// Synchronous register-array FIFO; head is read through the registered read pointer.
module lix_fifo_s
  import lix_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned D  = 4,
  parameter int unsigned CW = lix_cnt_w(D)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] cnt_o,
  output logic          empty_o
);

  localparam int unsigned AW = lix_ptr_w(D);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_c;

  // Pointers wrap explicitly at D-1 so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = ptr_inc(wr_q);
    if (pop_i)  rd_d = ptr_inc(rd_q);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(D); i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i) mem_q[wr_q] <= dat_i;
    end
  end

  assign full_c  = (cnt_q == CW'(D));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign head_o  = mem_q[rd_q];

  `LIX_ASSERT_NEVER(clk_i, rst_i, push_i && full_c, "lix_fifo_s: push while full")
  `LIX_ASSERT_NEVER(clk_i, rst_i, pop_i && empty_o, "lix_fifo_s: pop while empty")

endmodule

// File: rtl/lix_shr_drain.sv
// Output-side companion for the lix_shr0 delay line: shadows token valids, buffers
// arriving words in a FIFO and throttles the delay line from FIFO occupancy.
module lix_shr_drain
  import lix_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 2,
  parameter int unsigned D  = 4,
  parameter int unsigned CW = lix_cnt_w(D)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          s_vld,
  output logic          s_rdy,
  output logic          o_en,
  input  logic [W-1:0]  i_z,
  output logic          m_vld,
  input  logic          m_rdy,
  output logic [W-1:0]  m_dat,
  output logic [CW-1:0] o_cnt
);

  logic [N-1:0] v_q, v_d;
  logic         fresh_q;
  logic         push_c;
  logic         pop_c;
  logic         empty_c;
  logic [CW:0]  occ_c;

  // Shadow valid chain moves in lockstep with the delay line.
  always_comb begin
    v_d = v_q;
    if (o_en) begin
      v_d[0] = s_vld;
      for (int k = 1; k < int'(N); k++) v_d[k] = v_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q     <= '0;
      fresh_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      fresh_q <= o_en;
    end
  end

  // i_z only carries a new word in the cycle after an enabled shift.
  assign push_c = fresh_q & v_q[N-1];
  assign pop_c  = m_vld & m_rdy;

  // Reserve a slot for the one word that may still land next cycle.
  assign occ_c  = {1'b0, o_cnt} + (CW+1)'(push_c);
  assign o_en   = (occ_c < (CW+1)'(D));
  assign s_rdy  = o_en;
  assign m_vld  = ~empty_c;

  lix_fifo_s #(
    .W  (W),
    .D  (D),
    .CW (CW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_c),
    .dat_i   (i_z),
    .pop_i   (pop_c),
    .head_o  (m_dat),
    .cnt_o   (o_cnt),
    .empty_o (empty_c)
  );

endmodule

// File: tb/tb_lix_shr_drain.sv
// Bench for lix_shr_drain: three depth configurations share one stimulus stream,
// each with a delay-line model in front and an in-order scoreboard behind.
module tb_lix_shr_drain;

  localparam int LOGN = 4096;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        s_vld;
  logic [31:0] s_dat;
  logic        m_rdy;

  logic        a_rdy, a_en, a_mvld;
  logic [31:0] a_mdat, a_z;
  logic [2:0]  a_cnt;
  logic        b_rdy, b_en, b_mvld;
  logic [31:0] b_mdat, b_z;
  logic [1:0]  b_cnt;
  logic        c_rdy, c_en, c_mvld;
  logic [31:0] c_mdat, c_z;
  logic [1:0]  c_cnt;

  logic [31:0] za [2];
  logic [31:0] zc [4];
  logic [31:0] zb;

  always #5 clk_i = ~clk_i;

  // Delay-line models (lix_shr0 behaviour): shift on enable, no reset.
  always @(posedge clk_i) if (a_en) begin za[0] <= s_dat; za[1] <= za[0]; end
  always @(posedge clk_i) if (b_en) zb <= s_dat;
  always @(posedge clk_i) if (c_en) begin
    zc[0] <= s_dat;
    for (int k = 1; k < 4; k++) zc[k] <= zc[k-1];
  end
  assign a_z = za[1];
  assign b_z = zb;
  assign c_z = zc[3];

  lix_shr_drain #(.W(32), .N(2), .D(4)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .s_vld(s_vld), .s_rdy(a_rdy), .o_en(a_en),
    .i_z(a_z), .m_vld(a_mvld), .m_rdy(m_rdy), .m_dat(a_mdat), .o_cnt(a_cnt));
  lix_shr_drain #(.W(32), .N(1), .D(2)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .s_vld(s_vld), .s_rdy(b_rdy), .o_en(b_en),
    .i_z(b_z), .m_vld(b_mvld), .m_rdy(m_rdy), .m_dat(b_mdat), .o_cnt(b_cnt));
  lix_shr_drain #(.W(32), .N(4), .D(3)) dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .s_vld(s_vld), .s_rdy(c_rdy), .o_en(c_en),
    .i_z(c_z), .m_vld(c_mvld), .m_rdy(m_rdy), .m_dat(c_mdat), .o_cnt(c_cnt));

  int n_vec = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int a_acc_n = 0, b_acc_n = 0, c_acc_n = 0;
  int a_pops = 0;
  logic a_acc_last;

  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic [31:0] qc [$];

  int a_mv_log [LOGN];
  int a_en_log [LOGN];
  int a_cnt_log [LOGN];
  int b_mv_log [LOGN];
  int b_en_log [LOGN];
  int b_cnt_log [LOGN];
  int c_mv_log [LOGN];
  int c_en_log [LOGN];
  int c_cnt_log [LOGN];
  int rdy_log [LOGN];
  logic [31:0] a_dat_log [LOGN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, score accepts/pops, advance.
  task automatic cyc(input logic vld, input logic [31:0] dat, input logic rdy, input logic rst);
    s_vld = vld; s_dat = dat; m_rdy = rdy; rst_i = rst;
    #1;
    if (cyc_n < LOGN) begin
      a_mv_log[cyc_n] = int'(a_mvld); a_en_log[cyc_n] = int'(a_en); a_cnt_log[cyc_n] = int'(a_cnt);
      b_mv_log[cyc_n] = int'(b_mvld); b_en_log[cyc_n] = int'(b_en); b_cnt_log[cyc_n] = int'(b_cnt);
      c_mv_log[cyc_n] = int'(c_mvld); c_en_log[cyc_n] = int'(c_en); c_cnt_log[cyc_n] = int'(c_cnt);
      rdy_log[cyc_n] = int'(rdy);     a_dat_log[cyc_n] = a_mdat;
    end
    a_acc_last = vld & a_rdy & ~rst;
    if (rst) begin
      qa.delete(); qb.delete(); qc.delete();
    end else begin
      if (a_mvld && rdy) begin
        chk("a_pop_nonempty", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) chk("a_dat", a_mdat, qa.pop_front());
        a_pops++;
      end
      if (b_mvld && rdy) begin
        chk("b_pop_nonempty", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) chk("b_dat", b_mdat, qb.pop_front());
      end
      if (c_mvld && rdy) begin
        chk("c_pop_nonempty", 32'(qc.size() != 0), 32'd1);
        if (qc.size() != 0) chk("c_dat", c_mdat, qc.pop_front());
      end
      if (vld && a_rdy) begin qa.push_back(dat); a_acc_n++; end
      if (vld && b_rdy) begin qb.push_back(dat); b_acc_n++; end
      if (vld && c_rdy) begin qc.push_back(dat); c_acc_n++; end
    end
    @(negedge clk_i);
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    int t, t0, t1, t2, t3, t4, r, f, k, j, b0, p0, cov, mx;
    logic ok_a, ok_c, vld, rdy;
    logic [31:0] tok;
    int pat [6];
    pat = '{1, 0, 1, 1, 0, 1};

    rst_i = 1'b1; s_vld = 1'b0; s_dat = '0; m_rdy = 1'b0;
    @(negedge clk_i);

    // Reset values
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    t = cyc_n;
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("rst_a_mvld", 32'(a_mv_log[t]), 32'd0);
    chk("rst_a_cnt",  32'(a_cnt_log[t]), 32'd0);
    chk("rst_a_en",   32'(a_en_log[t]), 32'd1);
    chk("rst_a_mdat", a_dat_log[t], 32'd0);
    chk("rst_b_en",   32'(b_en_log[t]), 32'd1);
    chk("rst_b_cnt",  32'(b_cnt_log[t]), 32'd0);
    chk("rst_c_en",   32'(c_en_log[t]), 32'd1);
    chk("rst_c_mvld", 32'(c_mv_log[t]), 32'd0);

    // Smoke: 8 back-to-back tokens, always ready downstream
    t0 = cyc_n; b0 = b_acc_n;
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h10 + 32'(i), 1'b1, 1'b0);
    idle(14);
    chk("smoke_a_early", 32'(a_mv_log[t0+2]), 32'd0);
    ok_a = 1'b1; ok_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ok_a &= (a_mv_log[t0+3+i] == 1);
      ok_c &= (c_mv_log[t0+5+i] == 1);
    end
    chk("smoke_a_nogap", 32'(ok_a), 32'd1);
    chk("smoke_a_first", a_dat_log[t0+3], 32'h10);
    chk("smoke_a_last",  a_dat_log[t0+10], 32'h17);
    chk("smoke_a_after", 32'(a_mv_log[t0+11]), 32'd0);
    chk("smoke_c_early", 32'(c_mv_log[t0+4]), 32'd0);
    chk("smoke_c_nogap", 32'(ok_c), 32'd1);
    ok_a = 1'b1; ok_c = 1'b1;
    for (int i = 0; i < 13; i++) begin
      ok_a &= (a_en_log[t0+i] == 1);
      ok_c &= (c_en_log[t0+i] == 1);
    end
    chk("smoke_a_en_high", 32'(ok_a), 32'd1);
    chk("smoke_c_en_high", 32'(ok_c), 32'd1);
    chk("smoke_b_rate", 32'((b_acc_n - b0) >= 4), 32'd1);

    // Bubbles: output valid pattern is the input pattern shifted by 3
    t1 = cyc_n;
    for (int i = 0; i < 6; i++) cyc(pat[i] != 0, 32'hA0 + 32'(i), 1'b1, 1'b0);
    idle(12);
    for (int i = 0; i < 6; i++) chk($sformatf("bubble_mvld_%0d", i), 32'(a_mv_log[t1+3+i]), 32'(pat[i]));
    chk("bubble_tail", 32'(a_mv_log[t1+9]), 32'd0);

    // Back-pressure: 10 words, downstream stalled from phase cycle 2 to 21
    t2 = cyc_n; p0 = a_pops; k = 0; j = 0;
    while ((k < 10 || j < 22) && j < 80) begin
      rdy = (j < 2) || (j >= 22);
      cyc(k < 10, 32'hB0 + 32'(k), rdy, 1'b0);
      if (a_acc_last) k++;
      j++;
    end
    idle(15);
    chk("bp_all_accepted", 32'(k), 32'd10);
    r = t2 + 22;
    mx = 0; f = -1;
    for (int c = t2; c < r; c++) begin
      if (a_cnt_log[c] > mx) mx = a_cnt_log[c];
      if (f < 0 && a_cnt_log[c] == 4) f = c;
    end
    chk("bp_cnt_max", 32'(mx), 32'd4);
    chk("bp_full_seen", 32'(f > t2), 32'd1);
    if (f > t2) chk("bp_en_falls_with_last_push", 32'(a_en_log[f-1]), 32'd0);
    chk("bp_cnt_stalled", 32'(a_cnt_log[r-1]), 32'd4);
    chk("bp_en_at_release", 32'(a_en_log[r]), 32'd0);
    chk("bp_en_restart", 32'(a_en_log[r+1]), 32'd1);
    chk("bp_delivered", 32'(a_pops - p0), 32'd10);
    chk("bp_qa_empty", 32'(qa.size()), 32'd0);

    // Random traffic: 200 words, 50% downstream ready
    t3 = cyc_n; p0 = a_pops; k = 0; j = 0; tok = $urandom;
    while (k < 200 && j < 3000) begin
      vld = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 1) == 1);
      cyc(vld, tok, rdy, 1'b0);
      if (a_acc_last) begin k++; tok = $urandom; end
      j++;
    end
    idle(30);
    chk("rand_all_accepted", 32'(k), 32'd200);
    chk("rand_delivered", 32'(a_pops - p0), 32'd200);
    cov = 0;
    for (int c = t3; c < cyc_n - 1 && c < LOGN - 1; c++)
      if (a_cnt_log[c] == 3 && a_mv_log[c] == 1 && rdy_log[c] == 1 && a_cnt_log[c+1] == 3) cov++;
    chk("rand_cover_pushpop_cnt3", 32'(cov > 0), 32'd1);
    chk("rand_qa_empty", 32'(qa.size()), 32'd0);
    chk("rand_qb_empty", 32'(qb.size()), 32'd0);
    chk("rand_qc_empty", 32'(qc.size()), 32'd0);

    // Reset mid-stream with 2 buffered words and 2 tokens in flight
    t4 = cyc_n;
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("mid_cnt_before", 32'(a_cnt_log[t4+4]), 32'd2);
    cyc(1'b1, 32'h55, 1'b1, 1'b0);
    chk("mid_mvld_after", 32'(a_mv_log[t4+5]), 32'd0);
    chk("mid_cnt_after",  32'(a_cnt_log[t4+5]), 32'd0);
    chk("mid_en_after",   32'(a_en_log[t4+5]), 32'd1);
    idle(12);
    chk("mid_no_stale_1", 32'(a_mv_log[t4+6]), 32'd0);
    chk("mid_no_stale_2", 32'(a_mv_log[t4+7]), 32'd0);
    chk("mid_first_vld",  32'(a_mv_log[t4+8]), 32'd1);
    chk("mid_first_word", a_dat_log[t4+8], 32'h55);
    chk("end_qa_empty", 32'(qa.size()), 32'd0);
    chk("end_qb_empty", 32'(qb.size()), 32'd0);
    chk("end_qc_empty", 32'(qc.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
